// File: rtl/fpcvt_pkg.sv
// Shared widths for the linear-to-float converter and its scheduler.
package fpcvt_pkg;
  localparam int unsigned DEF_LIN_W = 12;
  localparam int unsigned DEF_EXP_W = 3;
  localparam int unsigned DEF_SIG_W = 4;
  localparam int unsigned ID_W      = 1;
endpackage

// File: rtl/fpcvt_sched_if.sv
// Two requester channels plus the converted-result channel.
interface fpcvt_sched_if
  import fpcvt_pkg::*;
#(
  parameter int unsigned LIN_W = DEF_LIN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned SIG_W = DEF_SIG_W
);
  logic             req0_valid;
  logic             req1_valid;
  logic [LIN_W-1:0] req0_d;
  logic [LIN_W-1:0] req1_d;
  logic             req0_ready;
  logic             req1_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic             out_s;
  logic [EXP_W-1:0] out_e;
  logic [SIG_W-1:0] out_f;

  modport slave (
    input  req0_valid, req1_valid, req0_d, req1_d, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_s, out_e, out_f
  );

  modport master (
    output req0_valid, req1_valid, req0_d, req1_d, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_s, out_e, out_f
  );
endinterface

// File: rtl/fpcvt_round.sv
// Normalise a magnitude to exponent/significand with round-half-up and saturation.
module fpcvt_round
  import fpcvt_pkg::*;
#(
  parameter int unsigned LIN_W = DEF_LIN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned SIG_W = DEF_SIG_W
) (
  input  logic [LIN_W-2:0] i_mag,
  output logic [EXP_W-1:0] o_e,
  output logic [SIG_W-1:0] o_f
);
  localparam int unsigned MAG_W = LIN_W - 1;
  localparam int unsigned NRM_W = MAG_W - SIG_W;
  localparam logic [EXP_W-1:0] E_MAX = '1;

  logic [EXP_W-1:0] w_e;
  logic [SIG_W:0]   w_sh;
  logic [SIG_W:0]   w_sum;

  // Exponent = position of the highest set bit above the significand field.
  always_comb begin
    w_e = '0;
    for (int i = 0; i < int'(NRM_W); i++) begin
      if (i_mag[SIG_W+i]) w_e = EXP_W'(i + 1);
    end
  end

  // Bit 0 of the shifted word is the round bit (zero when e is 0).
  assign w_sh  = (SIG_W+1)'({i_mag, 1'b0} >> w_e);
  assign w_sum = {1'b0, w_sh[SIG_W:1]} + (SIG_W+1)'(w_sh[0]);

  // Renormalise on significand overflow, saturating at the top exponent.
  always_comb begin
    o_e = w_e;
    o_f = w_sum[SIG_W-1:0];
    if (w_sum[SIG_W]) begin
      if (w_e == E_MAX) begin
        o_f = '1;
      end else begin
        o_e = w_e + EXP_W'(1);
        o_f = {1'b1, {(SIG_W-1){1'b0}}};
      end
    end
  end
endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin two-requester scheduler feeding a two-stage conversion pipeline.
module fpcvt_sched
  import fpcvt_pkg::*;
#(
  parameter int unsigned LIN_W = DEF_LIN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned SIG_W = DEF_SIG_W
) (
  input logic          clk,
  input logic          rst,
  fpcvt_sched_if.slave bus
);
  localparam int unsigned MAG_W = LIN_W - 1;
  localparam logic [LIN_W-1:0] D_MIN = {1'b1, {(LIN_W-1){1'b0}}};

  logic             r_last_grant;
  logic             r_s1_v;
  logic             r_s1_s;
  logic [ID_W-1:0]  r_s1_id;
  logic [MAG_W-1:0] r_s1_mag;
  logic             r_s2_v;
  logic             r_s2_s;
  logic [ID_W-1:0]  r_s2_id;
  logic [EXP_W-1:0] r_s2_e;
  logic [SIG_W-1:0] r_s2_f;

  logic             w_adv;
  logic             w_s1_load;
  logic             w_gnt;
  logic             w_acc;
  logic [LIN_W-1:0] w_d;
  logic [MAG_W-1:0] w_mag;
  logic [EXP_W-1:0] w_e;
  logic [SIG_W-1:0] w_f;

  // Flow control, arbitration and sign/magnitude split of the granted sample.
  always_comb begin
    w_adv     = !r_s2_v || bus.out_ready;
    w_s1_load = !r_s1_v || w_adv;
    w_gnt     = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    w_acc     = (bus.req0_valid || bus.req1_valid) && w_s1_load && !rst;
    w_d       = w_gnt ? bus.req1_d : bus.req0_d;
    if (w_d == D_MIN) begin
      w_mag = '1;
    end else if (w_d[LIN_W-1]) begin
      w_mag = MAG_W'(-w_d);
    end else begin
      w_mag = w_d[LIN_W-2:0];
    end
  end

  assign bus.req0_ready = w_acc && !w_gnt;
  assign bus.req1_ready = w_acc && w_gnt;

  // S1: capture the accepted sample and remember who won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v       <= 1'b0;
      r_s1_s       <= 1'b0;
      r_s1_id      <= '0;
      r_s1_mag     <= '0;
      r_last_grant <= 1'b1;
    end else if (w_s1_load) begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_s       <= w_d[LIN_W-1];
        r_s1_id      <= ID_W'(w_gnt);
        r_s1_mag     <= w_mag;
        r_last_grant <= w_gnt;
      end
    end
  end

  fpcvt_round #(
    .LIN_W (LIN_W),
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_round (
    .i_mag (r_s1_mag),
    .o_e   (w_e),
    .o_f   (w_f)
  );

  // S2: hold the rounded result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_s2_s  <= 1'b0;
      r_s2_id <= '0;
      r_s2_e  <= '0;
      r_s2_f  <= '0;
    end else if (w_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_s  <= r_s1_s;
        r_s2_id <= r_s1_id;
        r_s2_e  <= w_e;
        r_s2_f  <= w_f;
      end
    end
  end

  assign bus.out_valid = r_s2_v;
  assign bus.out_id    = r_s2_id;
  assign bus.out_s     = r_s2_s;
  assign bus.out_e     = r_s2_e;
  assign bus.out_f     = r_s2_f;
endmodule

// File: tb/tb_fpcvt_sched.sv
// Scoreboard bench for fpcvt_sched: drivers per requester, independent output monitor.
module tb_fpcvt_sched;
  import fpcvt_pkg::*;

  typedef struct packed {
    logic       id;
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpcvt_sched_if bus ();

  fpcvt_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t        exp_q[$];
  logic [11:0] src0[$];
  logic [11:0] src1[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Requester 0 driver: present queue head, pop once the handshake completes.
  initial begin : drv0
    bit hs;
    bus.req0_valid = 1'b0;
    bus.req0_d     = '0;
    forever begin
      @(negedge clk);
      hs = bus.req0_valid && bus.req0_ready;
      @(posedge clk);
      #1;
      if (hs && src0.size() > 0) void'(src0.pop_front());
      if (src0.size() > 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_d     = src0[0];
      end else begin
        bus.req0_valid = 1'b0;
      end
    end
  end

  // Requester 1 driver.
  initial begin : drv1
    bit hs;
    bus.req1_valid = 1'b0;
    bus.req1_d     = '0;
    forever begin
      @(negedge clk);
      hs = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (hs && src1.size() > 0) void'(src1.pop_front());
      if (src1.size() > 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_d     = src1[0];
      end else begin
        bus.req1_valid = 1'b0;
      end
    end
  end

  // Output monitor: compare taken results in order, and check hold under stall.
  initial begin : mon
    res_t got;
    res_t prev;
    bit   stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      got = {bus.out_id, bus.out_s, bus.out_e, bus.out_f};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) check("hold_stable", 32'({bus.out_valid, got}), 32'({1'b1, prev}));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got id/s/e/f 0x%0h, expected no output", got);
          end else begin
            check("result", 32'(got), 32'(exp_q.pop_front()));
          end
        end
        stall = bus.out_valid && !bus.out_ready;
        prev  = got;
      end
    end
  end

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL hs_timeout: got no handshake, expected one within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (src0.size() == 0) && (src1.size() == 0);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
    end
  endtask

  task automatic send1(input bit req, input logic [11:0] d, input res_t r);
    @(negedge clk);
    exp_q.push_back(r);
    if (req) src1.push_back(d);
    else     src0.push_back(d);
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin : main
    bit ok;
    int cnt;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_out_s", 32'(bus.out_s), 32'd0);
    check("rst_out_e", 32'(bus.out_e), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    #1 rst = 1'b0;

    // Single sample with two-cycle latency.
    @(negedge clk);
    exp_q.push_back('{id: 1'b0, s: 1'b0, e: 3'd4, f: 4'd8});
    src0.push_back(12'd125);
    wait_hs(ok);
    @(negedge clk);
    check("latency_c1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_c2_valid", 32'(bus.out_valid), 32'd1);
    wait_drain();

    // Directed singles across both requesters.
    send1(1'b1, 12'd44,   '{id: 1'b1, s: 1'b0, e: 3'd2, f: 4'd11});
    send1(1'b0, 12'd5,    '{id: 1'b0, s: 1'b0, e: 3'd0, f: 4'd5});
    send1(1'b0, 12'h800,  '{id: 1'b0, s: 1'b1, e: 3'd7, f: 4'd15});
    send1(1'b1, 12'h7FF,  '{id: 1'b1, s: 1'b0, e: 3'd7, f: 4'd15});
    send1(1'b0, 12'hF83,  '{id: 1'b0, s: 1'b1, e: 3'd4, f: 4'd8});
    send1(1'b1, 12'd16,   '{id: 1'b1, s: 1'b0, e: 3'd1, f: 4'd8});
    send1(1'b0, 12'd31,   '{id: 1'b0, s: 1'b0, e: 3'd2, f: 4'd8});
    send1(1'b1, 12'd0,    '{id: 1'b1, s: 1'b0, e: 3'd0, f: 4'd0});
    send1(1'b0, 12'd15,   '{id: 1'b0, s: 1'b0, e: 3'd0, f: 4'd15});
    send1(1'b1, 12'd1000, '{id: 1'b1, s: 1'b0, e: 3'd7, f: 4'd8});
    send1(1'b0, 12'd200,  '{id: 1'b0, s: 1'b0, e: 3'd4, f: 4'd13});

    // Contention right after reset: requester 0 first, then alternate each cycle.
    do_reset();
    @(negedge clk);
    exp_q.push_back('{id: 1'b0, s: 1'b0, e: 3'd1, f: 4'd8});
    exp_q.push_back('{id: 1'b1, s: 1'b0, e: 3'd4, f: 4'd13});
    exp_q.push_back('{id: 1'b0, s: 1'b0, e: 3'd2, f: 4'd8});
    exp_q.push_back('{id: 1'b1, s: 1'b0, e: 3'd7, f: 4'd8});
    src0.push_back(12'd16);
    src0.push_back(12'd31);
    src1.push_back(12'd200);
    src1.push_back(12'd1000);
    wait_hs(ok);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) cnt++;
    end
    check("contention_accepts", 32'(cnt), 32'd3);
    wait_drain();

    // Backpressure: five stalled cycles admit exactly two samples.
    @(posedge clk);
    #2 bus.out_ready = 1'b0;
    @(negedge clk);
    exp_q.push_back('{id: 1'b0, s: 1'b0, e: 3'd4, f: 4'd8});
    exp_q.push_back('{id: 1'b1, s: 1'b0, e: 3'd2, f: 4'd11});
    exp_q.push_back('{id: 1'b0, s: 1'b1, e: 3'd4, f: 4'd8});
    exp_q.push_back('{id: 1'b1, s: 1'b1, e: 3'd2, f: 4'd11});
    src0.push_back(12'd125);
    src0.push_back(12'hF83);
    src1.push_back(12'd44);
    src1.push_back(12'hFD4);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) cnt++;
    end
    check("bp_accepts", 32'(cnt), 32'd2);
    check("bp_ready0", 32'(bus.req0_ready), 32'd0);
    check("bp_ready1", 32'(bus.req1_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    wait_drain();

    // Reset with two samples in flight and a third still offered.
    @(posedge clk);
    #2 bus.out_ready = 1'b0;
    @(negedge clk);
    src0.push_back(12'd5);
    src0.push_back(12'h400);
    src1.push_back(12'd44);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) cnt++;
    end
    check("midrst_accepts", 32'(cnt), 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready0", 32'(bus.req0_ready), 32'd0);
    check("midrst_ready1", 32'(bus.req1_ready), 32'd0);
    src0.delete();
    src1.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("postrst_no_stale", 32'(cnt), 32'd0);
    send1(1'b1, 12'h400, '{id: 1'b1, s: 1'b0, e: 3'd7, f: 4'd8});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, expected completion within 100000 time units");
    $fatal(1, "timeout");
  end
endmodule
